// File: rtl/seq_comb_pkg.sv
// rtl/seq_comb_pkg.sv - shared types and helpers for the propagation probe
package seq_comb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // All-ones code of the given width, used as the "no bad bit seen" marker.
  function automatic logic [31:0] no_bad_bit(input int w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    if (v >= max_v) return v;
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_comb_paths.sv
// rtl/seq_comb_paths.sv - four zero-delay copies of the stimulus plus a registered copy
module seq_comb_paths
  import seq_comb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] out_cont,
  output logic [WIDTH-1:0] out_proc,
  output logic [WIDTH-1:0] out_gate_buf,
  output logic [WIDTH-1:0] out_gate_and,
  output logic [WIDTH-1:0] out_reg
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  assign out_cont = a;

  // Procedural copy of the stimulus.
  always_comb begin
    out_proc = a;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_gate
    buf u_buf (out_gate_buf[i], a[i]);
    and u_and (out_gate_and[i], a[i], a[i]);
  end

  // Next value of the shift register: a enters stage 0, each stage feeds the next.
  always_comb begin
    stage_d[0] = a;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Shift register state, cleared by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) stage_q[i] <= '0;
      else     stage_q[i] <= stage_d[i];
    end
  end

  assign out_reg = stage_q[DEPTH-1];

endmodule

// File: rtl/seq_comb_probe.sv
// rtl/seq_comb_probe.sv - checker FSM that compares every path against the stimulus
module seq_comb_probe
  import seq_comb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [WIDTH-1:0]           a,
  output logic [WIDTH-1:0]           out_cont,
  output logic [WIDTH-1:0]           out_proc,
  output logic [WIDTH-1:0]           out_gate_buf,
  output logic [WIDTH-1:0]           out_gate_and,
  output logic [WIDTH-1:0]           out_reg,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_W-1:0]           sample_cnt,
  output logic [CNT_W-1:0]           mismatch_cnt,
  output logic [$clog2(WIDTH):0]     first_bad_bit
);

  localparam int BB_W   = $clog2(WIDTH) + 1;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [BB_W-1:0] NO_BAD = BB_W'(no_bad_bit(BB_W));
  localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << CNT_W) - 32'd1);

  state_e            state_q, state_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]  sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
  logic [BB_W-1:0]   first_bad_q, first_bad_d;
  logic [WIDTH-1:0]  hist_q [DEPTH];
  logic [WIDTH-1:0]  hist_d [DEPTH];

  logic [WIDTH-1:0]  diff_comb;
  logic [WIDTH-1:0]  diff_reg;
  logic              any_bad;
  logic [BB_W-1:0]   bad_idx;

  seq_comb_paths #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_paths (
    .clk          (clk),
    .rst          (rst),
    .a            (a),
    .out_cont     (out_cont),
    .out_proc     (out_proc),
    .out_gate_buf (out_gate_buf),
    .out_gate_and (out_gate_and),
    .out_reg      (out_reg)
  );

  // Independent history of a, so the registered path is judged against the checker's own copy.
  always_comb begin
    hist_d[0] = a;
    for (int i = 1; i < DEPTH; i++) begin
      hist_d[i] = hist_q[i-1];
    end
  end

  // Disagreement detection; comb paths take priority over the registered path for the bit index.
  always_comb begin
    diff_comb = (out_cont ^ a) | (out_proc ^ a) | (out_gate_buf ^ a) | (out_gate_and ^ a);
    diff_reg  = out_reg ^ hist_q[DEPTH-1];
    any_bad   = (diff_comb != '0) || (diff_reg != '0);
    bad_idx   = NO_BAD;
    if (diff_comb != '0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (diff_comb[i]) bad_idx = BB_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (diff_reg[i]) bad_idx = BB_W'(i);
      end
    end
  end

  // Next-state and counter logic for the IDLE/FILL/RUN/DONE checker.
  always_comb begin
    state_d        = state_q;
    fill_cnt_d     = fill_cnt_q;
    sample_cnt_d   = sample_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    first_bad_d    = first_bad_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = FILL;
          fill_cnt_d     = '0;
          sample_cnt_d   = '0;
          mismatch_cnt_d = '0;
          first_bad_d    = NO_BAD;
        end
      end
      FILL: begin
        if (stop) begin
          state_d = DONE;
        end else if (fill_cnt_q == FILL_W'(DEPTH - 1)) begin
          state_d = RUN;
        end else begin
          fill_cnt_d = fill_cnt_q + FILL_W'(1);
        end
      end
      RUN: begin
        sample_cnt_d = CNT_W'(sat_inc(32'(sample_cnt_q), CNT_MAX));
        if (any_bad) begin
          mismatch_cnt_d = CNT_W'(sat_inc(32'(mismatch_cnt_q), CNT_MAX));
          if (first_bad_q == NO_BAD) first_bad_d = bad_idx;
        end
        if (stop) state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d        = FILL;
          fill_cnt_d     = '0;
          sample_cnt_d   = '0;
          mismatch_cnt_d = '0;
          first_bad_d    = NO_BAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Checker state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      fill_cnt_q     <= '0;
      sample_cnt_q   <= '0;
      mismatch_cnt_q <= '0;
      first_bad_q    <= NO_BAD;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else begin
      state_q        <= state_d;
      fill_cnt_q     <= fill_cnt_d;
      sample_cnt_q   <= sample_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      first_bad_q    <= first_bad_d;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= hist_d[i];
    end
  end

  assign busy          = (state_q == FILL) || (state_q == RUN);
  assign done          = (state_q == DONE);
  assign sample_cnt    = sample_cnt_q;
  assign mismatch_cnt  = mismatch_cnt_q;
  assign first_bad_bit = first_bad_q;

endmodule

// File: tb/tb_seq_comb_probe.sv
// tb/tb_seq_comb_probe.sv - directed vector bench for seq_comb_probe
module tb_seq_comb_probe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] a = 8'h00;

  logic [7:0]  out_cont, out_proc, out_gate_buf, out_gate_and, out_reg;
  logic        busy, done;
  logic [15:0] sample_cnt, mismatch_cnt;
  logic [3:0]  first_bad_bit;

  logic [7:0]  s_cont, s_proc, s_buf, s_and, s_reg;
  logic        s_busy, s_done;
  logic [3:0]  s_sample, s_mismatch;
  logic [3:0]  s_fbb;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_comb_probe #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .a(a),
    .out_cont(out_cont), .out_proc(out_proc), .out_gate_buf(out_gate_buf),
    .out_gate_and(out_gate_and), .out_reg(out_reg), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .mismatch_cnt(mismatch_cnt), .first_bad_bit(first_bad_bit)
  );

  seq_comb_probe #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .a(a),
    .out_cont(s_cont), .out_proc(s_proc), .out_gate_buf(s_buf),
    .out_gate_and(s_and), .out_reg(s_reg), .busy(s_busy), .done(s_done),
    .sample_cnt(s_sample), .mismatch_cnt(s_mismatch), .first_bad_bit(s_fbb)
  );

  typedef struct {
    logic        start;
    logic        stop;
    logic [7:0]  a;
    logic        busy;
    logic        done;
    logic [15:0] scnt;
    logic [15:0] mcnt;
    logic [3:0]  fbb;
  } vec_t;

  vec_t vecs [15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic eb, input logic ed,
                              input logic [15:0] es, input logic [15:0] em, input logic [3:0] ef);
    check({tag, ".busy"}, 32'(busy), 32'(eb));
    check({tag, ".done"}, 32'(done), 32'(ed));
    check({tag, ".sample_cnt"}, 32'(sample_cnt), 32'(es));
    check({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), 32'(em));
    check({tag, ".first_bad_bit"}, 32'(first_bad_bit), 32'(ef));
  endtask

  task automatic check_comb(input string tag, input logic [7:0] ea);
    check({tag, ".out_cont"}, 32'(out_cont), 32'(ea));
    check({tag, ".out_proc"}, 32'(out_proc), 32'(ea));
    check({tag, ".out_gate_buf"}, 32'(out_gate_buf), 32'(ea));
    check({tag, ".out_gate_and"}, 32'(out_gate_and), 32'(ea));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Main run table: start, two FILL edges, ten RUN edges, stop edge, one DONE hold.
    for (int i = 0; i < 15; i++) begin
      vecs[i].start = (i == 0);
      vecs[i].stop  = (i == 13);
      vecs[i].a     = 8'(i * 7 + 1);
      vecs[i].busy  = (i <= 12);
      vecs[i].done  = (i >= 13);
      vecs[i].scnt  = (i <= 2) ? 16'd0 : (i >= 13 ? 16'd11 : 16'(i - 2));
      vecs[i].mcnt  = 16'd0;
      vecs[i].fbb   = 4'hF;
    end

    tick();
    tick();
    rst = 1'b0;
    check("reset.out_reg", 32'(out_reg), 32'h0);
    check_status("reset", 1'b0, 1'b0, 16'd0, 16'd0, 4'hF);

    a = 8'hA5;
    #1;
    check_comb("idle_a5", 8'hA5);
    tick();
    check("idle.out_reg_1edge", 32'(out_reg), 32'h00);
    tick();
    check("idle.out_reg_2edge", 32'(out_reg), 32'hA5);
    check_status("idle", 1'b0, 1'b0, 16'd0, 16'd0, 4'hF);

    for (int i = 0; i < 15; i++) begin
      start = vecs[i].start;
      stop  = vecs[i].stop;
      a     = vecs[i].a;
      tick();
      check_status($sformatf("vec%0d", i), vecs[i].busy, vecs[i].done,
                   vecs[i].scnt, vecs[i].mcnt, vecs[i].fbb);
    end
    start = 1'b0;
    stop  = 1'b0;

    // Fault injection on the procedural path for two RUN cycles.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_status("restart", 1'b1, 1'b0, 16'd0, 16'd0, 4'hF);
    tick();
    tick();
    a = 8'h5A;
    force dut.out_proc = 8'h52;
    tick();
    tick();
    release dut.out_proc;
    #1;
    check_comb("released", 8'h5A);
    tick();
    check_status("force", 1'b1, 1'b0, 16'd3, 16'd2, 4'd3);

    // start and stop together in RUN: stop wins, stop cycle sampled.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check_status("start_stop_run", 1'b0, 1'b1, 16'd4, 16'd2, 4'd3);

    // start alone in DONE clears counters and raises busy.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_status("done_restart", 1'b1, 1'b0, 16'd0, 16'd0, 4'hF);

    // Saturation: 20 RUN edges on the 4-bit counter instance.
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      a = 8'(i + 8'h30);
      tick();
    end
    check("sat.sample_cnt16", 32'(sample_cnt), 32'd20);
    check("sat.sample_cnt4", 32'(s_sample), 32'd15);
    check("sat.mismatch_cnt4", 32'(s_mismatch), 32'd0);

    // Three mismatching RUN cycles, then reset mid-run with start asserted.
    a = 8'hC3;
    force dut.out_proc = 8'hC1;
    tick();
    tick();
    tick();
    release dut.out_proc;
    check_status("pre_rst", 1'b1, 1'b0, 16'd23, 16'd3, 4'd1);

    rst   = 1'b1;
    start = 1'b1;
    a     = 8'h3C;
    tick();
    check_status("mid_rst", 1'b0, 1'b0, 16'd0, 16'd0, 4'hF);
    check("mid_rst.out_reg", 32'(out_reg), 32'h0);
    check("mid_rst.sample_cnt4", 32'(s_sample), 32'd0);
    check_comb("mid_rst", 8'h3C);
    a = 8'h81;
    #1;
    check_comb("mid_rst_track", 8'h81);
    rst   = 1'b0;
    start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_comb_probe.md
Name: seq_comb_probe

Overview:
- Parametrised, clocked successor to the single-bit zero-delay propagation probe.
- Drives a WIDTH-bit stimulus through four zero-delay paths (continuous assign, always_comb, buf primitive, and primitive) and one DEPTH-stage registered path.
- A checker FSM samples every path each cycle and counts disagreements, proving all paths settle within the same time step.
- Simulation/scheduling example, not synthesised into product logic.

Parameters:
- WIDTH, 8: stimulus and path width in bits (>=1).
- DEPTH, 2: stages in the registered path (>=1).
- CNT_W, 16: width of sample/mismatch counters.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a measurement run (pulse).
- stop  in  1  end the run (pulse).
- a  in  WIDTH  stimulus.
- out_cont  out  WIDTH  continuous-assign copy of a.
- out_proc  out  WIDTH  always_comb copy of a.
- out_gate_buf  out  WIDTH  per-bit buf primitive copy of a.
- out_gate_and  out  WIDTH  per-bit and(a,a) primitive copy of a.
- out_reg  out  WIDTH  a delayed by DEPTH clocks.
- busy  out  1  FSM in FILL or RUN.
- done  out  1  FSM in DONE.
- sample_cnt  out  CNT_W  cycles checked in RUN.
- mismatch_cnt  out  CNT_W  cycles with any path disagreement.
- first_bad_bit  out  $clog2(WIDTH)+1  lowest mismatching bit index of first mismatch; all-ones = none.

Behaviour:
- Comb paths: all four equal a in the same time step, no clock involvement, unaffected by rst.
- Registered path: shift register of DEPTH stages; on rst every stage and out_reg clear to 0.
- Reset values: busy=0, done=0, sample_cnt=0, mismatch_cnt=0, first_bad_bit=all-ones, FSM=IDLE.
- FSM states IDLE, FILL, RUN, DONE:
  - IDLE: start -> FILL; fill counter loads 0.
  - FILL: counts DEPTH cycles, then -> RUN, so out_reg holds valid history. stop in FILL -> DONE with counters unchanged.
  - RUN: each posedge, sample_cnt++.
    - Mismatch when any comb path != a, or out_reg != the checker's own DEPTH-deep history of a.
    - On mismatch: mismatch_cnt++; first_bad_bit latched on the first mismatch only (lowest differing bit, comb paths checked before the registered path).
    - stop -> DONE; the cycle with stop is still sampled.
  - DONE: holds all counters. start -> FILL and clears counters and first_bad_bit in the same edge.
- start and stop asserted in the same cycle: stop wins in FILL/RUN; start wins in IDLE/DONE.
- Counters saturate at 2^CNT_W-1; no wrap.
- rst mid-run: returns to IDLE next edge, all outputs to reset values, regardless of start/stop.
- Latency: out_reg = a from exactly DEPTH edges earlier; busy rises one edge after start.

Decomposition:
- Shared package seq_comb_pkg:
  - state_e enum (IDLE, FILL, RUN, DONE).
  - NO_BAD_BIT constant helper.
  - Saturating-increment function.
- One natural sub-module, seq_comb_paths: the four zero-delay paths plus the DEPTH-stage register. Checker/FSM stays in the top level.

Test Plan:
- Reset then idle, a=8'h00→8'hA5 with no start -> all four comb outputs read 8'hA5 in the same time step as the write; out_reg=8'hA5 after 2 edges; counters 0, first_bad_bit=all-ones.
- start, 2 FILL cycles, 10 RUN cycles of incrementing a, stop -> done=1, sample_cnt=11 (includes stop cycle), mismatch_cnt=0.
- Force out_proc bit 3 wrong for 2 RUN cycles via bench force -> mismatch_cnt=2, first_bad_bit=3.
- start and stop both high in RUN -> DONE. Then start alone in DONE -> counters clear, busy=1 next edge.
- CNT_W=4, 20 RUN cycles -> sample_cnt saturates at 15.
- rst asserted mid-RUN with mismatch_cnt=3 -> next edge IDLE, all counters 0, out_reg=0, comb outputs still track a.
